// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Round-robin sequencer that time-shares one external combinational ALU
//   between two requesters. It accepts one operation at a time, latches the
//   operands, drives the ALU for a single cycle, registers the result and
//   presents it on a valid/ready response port tagged with the requester id.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a request; grant and accept happen here
//   EXEC  | latched operands on alu_a/b/op, result captured at the edge
//   HOLD  | rsp_valid high, waiting for rsp_ready
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready/a/b/op    requester N operation and accept strobe
//   alu_a/alu_b/alu_op, alu_z  shared ALU operands out, result in
//   rsp_valid/ready/data/id    registered result and its requester id
module alu_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_id_q, last_id_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic grant_id;
  logic accept;

  // On a tie the requester not served last wins; otherwise whichever is
  // valid. The value is only meaningful when accept is high.
  assign grant_id = (req0_valid && req1_valid) ? ~last_id_q : ~req0_valid;
  assign accept   = (state_q == ST_IDLE) && (req0_valid || req1_valid);

  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_EXEC;
          last_id_d = grant_id;
          id_d      = grant_id;
          a_d       = grant_id ? req1_a  : req0_a;
          b_d       = grant_id ? req1_b  : req0_b;
          op_d      = grant_id ? req1_op : req0_op;
        end
      end
      ST_EXEC: begin
        rsp_data_d = alu_z;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_id_q  <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Ready is gated by rst_n so a held-valid requester sees no grant while
  // the block is being reset (state_q already reads IDLE then).
  assign req0_ready = rst_n && accept && !grant_id;
  assign req1_ready = rst_n && accept &&  grant_id;

  assign alu_a  = (state_q == ST_EXEC) ? a_q  : '0;
  assign alu_b  = (state_q == ST_EXEC) ? b_q  : '0;
  assign alu_op = (state_q == ST_EXEC) ? op_q : '0;

  assign rsp_valid = (state_q == ST_HOLD);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic [15:0] alu_a, alu_b, alu_z;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;

  int total = 0;
  int bad   = 0;

  // expected responses: {id, data}
  logic [16:0] exp_q[$];

  alu_share_arbiter #(.WIDTH(16), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  // shared ALU: 0 AND, 1 OR, 2 ADD, others XOR
  always_comb begin
    alu_z = 16'h0000;
    case (alu_op)
      3'd0: alu_z = alu_a & alu_b;
      3'd1: alu_z = alu_a | alu_b;
      3'd2: alu_z = alu_a + alu_b;
      default: alu_z = alu_a ^ alu_b;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: one handshake per HOLD cycle
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d data=%h expected none", rsp_id, rsp_data);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[16]});
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
    step();
    step();
    // reset state, with a requester already valid
    req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 0);
    chk("rst_alu_a", {16'd0, alu_a}, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // 1: single AND op from requester 0
    req0_valid = 1'b1; req0_a = 16'hF0F0; req0_b = 16'h0FF0; req0_op = 3'd0;
    rsp_ready = 1'b1;
    #1;
    chk("t1_req0_ready", {31'd0, req0_ready}, 1);
    chk("t1_req1_ready", {31'd0, req1_ready}, 0);
    exp_q.push_back({1'b0, 16'h00F0});
    step();
    req0_valid = 1'b0;
    chk("t1_exec_alu_a", {16'd0, alu_a}, 32'hF0F0);
    chk("t1_exec_alu_b", {16'd0, alu_b}, 32'h0FF0);
    chk("t1_exec_ready", {31'd0, req0_ready}, 0);
    chk("t1_exec_rsp_valid", {31'd0, rsp_valid}, 0);
    step();
    chk("t1_hold_rsp_valid", {31'd0, rsp_valid}, 1);
    step();
    chk("t1_idle_rsp_valid", {31'd0, rsp_valid}, 0);

    // 2: tie from reset alternates 0,1,0,1
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111; req0_op = 3'd2;
    req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'h0F0F; req1_op = 3'd1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("t2_req0_ready", {31'd0, req0_ready}, (g % 2 == 0) ? 1 : 0);
      chk("t2_req1_ready", {31'd0, req1_ready}, (g % 2 == 1) ? 1 : 0);
      if (g % 2 == 0) exp_q.push_back({1'b0, 16'h2345});
      else            exp_q.push_back({1'b1, 16'h0FFF});
      step();
      step();
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // 3: ADD with carry out dropped, consumer stalls for 5 cycles
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001; req1_op = 3'd2;
    #1;
    chk("t3_req1_ready", {31'd0, req1_ready}, 1);
    exp_q.push_back({1'b1, 16'h0000});
    step();
    req1_valid = 1'b0; req1_a = 16'h1234;
    step();
    req0_valid = 1'b1; req0_a = 16'hAAAA; req0_b = 16'h5555; req0_op = 3'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", {31'd0, rsp_valid}, 1);
      chk("t3_hold_data", {16'd0, rsp_data}, 0);
      chk("t3_hold_id", {31'd0, rsp_id}, 1);
      chk("t3_hold_req0_ready", {31'd0, req0_ready}, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("t3_idle_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("t3_idle_req0_ready", {31'd0, req0_ready}, 1);

    // 4: operand changes after accept must not matter
    exp_q.push_back({1'b0, 16'hFFFF});
    step();
    req0_valid = 1'b0; req0_a = 16'h0000; req0_b = 16'h0000; req0_op = 3'd0;
    #1;
    chk("t4_exec_alu_a", {16'd0, alu_a}, 32'hAAAA);
    chk("t4_exec_alu_b", {16'd0, alu_b}, 32'h5555);
    chk("t4_exec_alu_op", {29'd0, alu_op}, 1);
    step();
    chk("t4_hold_alu_a", {16'd0, alu_a}, 0);
    chk("t4_hold_alu_b", {16'd0, alu_b}, 0);
    chk("t4_hold_alu_op", {29'd0, alu_op}, 0);
    chk("t4_hold_data", {16'd0, rsp_data}, 32'hFFFF);
    step();

    // 5: reset mid-EXEC, then mid-HOLD; ties afterwards go to requester 0
    req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; req0_op = 3'd2;
    step();
    chk("t5_exec_alu_a", {16'd0, alu_a}, 3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_alu_a", {16'd0, alu_a}, 0);
    chk("t5_rst_alu_op", {29'd0, alu_op}, 0);
    chk("t5_rst_req0_ready", {31'd0, req0_ready}, 0);
    chk("t5_rst_rsp_valid", {31'd0, rsp_valid}, 0);
    req1_valid = 1'b1; req1_a = 16'h00F0; req1_b = 16'h000F; req1_op = 3'd1;
    rst_n = 1'b1;
    #1;
    chk("t5_tie_req0_ready", {31'd0, req0_ready}, 1);
    chk("t5_tie_req1_ready", {31'd0, req1_ready}, 0);
    rsp_ready = 1'b0;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("t5_hold_valid", {31'd0, rsp_valid}, 1);
    chk("t5_hold_data", {16'd0, rsp_data}, 7);
    rst_n = 1'b0;
    #1;
    chk("t5_rst2_valid", {31'd0, rsp_valid}, 0);
    chk("t5_rst2_data", {16'd0, rsp_data}, 0);
    chk("t5_rst2_id", {31'd0, rsp_id}, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("t5_tie2_req0_ready", {31'd0, req0_ready}, 1);
    chk("t5_tie2_req1_ready", {31'd0, req1_ready}, 0);
    exp_q.push_back({1'b0, 16'h0007});
    rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    // 6: a request arriving during HOLD is ignored
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h00FF; req0_op = 3'd0;
    exp_q.push_back({1'b0, 16'h0034});
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_a = 16'h5555; req1_b = 16'h1111; req1_op = 3'd2;
    #1;
    chk("t6_hold_req1_ready", {31'd0, req1_ready}, 0);
    chk("t6_hold_valid", {31'd0, rsp_valid}, 1);
    step();
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t6_idle_rsp_valid", {31'd0, rsp_valid}, 0);
      step();
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
